sparse_feature_encoder: RTL and testbench



---
 rtl/sparse_feature_encoder_if.sv | 34 +++
 rtl/sparse_feature_encoder.sv | 159 +++++++++++++++
 tb/tb_sparse_feature_encoder.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sparse_feature_encoder_if.sv
// Sparse feature encoder bus: dense pixel input plus packed 4-lane sparse output.
// The master modport is the encoder side; the slave modport is its environment.
interface sparse_feature_encoder_if #(
    parameter int col_length         = 8,
    parameter int word_length        = 8,
    parameter int double_word_length = 16
);
    logic                          in_valid;
    logic                          in_ready;
    logic [word_length-1:0]        in_pixel;
    logic [double_word_length-1:0] in_channel;
    logic                          out_valid;
    logic                          out_ready;
    logic [word_length*4-1:0]      feature_value;
    logic [col_length*4-1:0]       feature_cols;
    logic [col_length*4-1:0]       feature_rows;
    logic [3:0]                    lane_mask;
    logic                          out_last;
    logic [double_word_length-1:0] out_channel;
    logic [double_word_length-1:0] feature_valid_num;
    logic                          frame_done;

    modport master (
        input  in_valid, in_pixel, in_channel, out_ready,
        output in_ready, out_valid, feature_value, feature_cols, feature_rows,
               lane_mask, out_last, out_channel, feature_valid_num, frame_done
    );

    modport slave (
        output in_valid, in_pixel, in_channel, out_ready,
        input  in_ready, out_valid, feature_value, feature_cols, feature_rows,
               lane_mask, out_last, out_channel, feature_valid_num, frame_done
    );
endinterface

// File: rtl/sparse_feature_encoder.sv
// Dense raster feature map to 4-lane sparse (value,row,col) beats with a per-frame non-zero count.
// Optional macro SPARSE_PRUNE_EN: also drop pixels whose magnitude is <= prune_threshold.
module sparse_feature_encoder #(
    parameter int col_length         = 8,
    parameter int word_length        = 8,
    parameter int double_word_length = 16,
    parameter int image_size         = 28,
    parameter int prune_threshold    = 2
) (
    input  logic clk,
    input  logic rst,
    sparse_feature_encoder_if.master bus
);
    typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;

    localparam logic [col_length-1:0] coord_max = col_length'(image_size - 1);

    state_t state, state_nxt;

    logic [col_length-1:0]         row, col, cur_row, cur_col;
    logic [double_word_length-1:0] cnt;
    logic [1:0]                    acc_fill;
    logic [word_length*4-1:0]      acc_value, ins_value, out_value;
    logic [col_length*4-1:0]       acc_rows, ins_rows, out_rows;
    logic [col_length*4-1:0]       acc_cols, ins_cols, out_cols;
    logic [3:0]                    acc_mask, ins_mask, out_mask;
    logic                          out_valid, out_last, frame_done;
    logic [double_word_length-1:0] out_channel, valid_num;
    logic                          keep, ready, accept, last_pix, emit, out_hs, last_hs;

`ifdef SPARSE_PRUNE_EN
    // Two's-complement magnitude; the most negative code reads as the largest unsigned value.
    logic [word_length-1:0] mag;
    assign mag  = bus.in_pixel[word_length-1] ? (~bus.in_pixel + word_length'(1)) : bus.in_pixel;
    assign keep = mag > word_length'(prune_threshold);
`else
    assign keep = bus.in_pixel != '0;
`endif

    // The first pixel of a frame is always (0,0), whatever the counters hold.
    always_comb begin
        cur_row  = (state == IDLE) ? '0 : row;
        cur_col  = (state == IDLE) ? '0 : col;
        last_pix = (cur_row == coord_max) && (cur_col == coord_max);
    end

    always_comb begin
        ins_value = acc_value;
        ins_rows  = acc_rows;
        ins_cols  = acc_cols;
        ins_mask  = acc_mask;
        for (int k = 0; k < 4; k++) begin
            if (keep && acc_fill == 2'(k)) begin
                ins_value[k*word_length +: word_length] = bus.in_pixel;
                ins_rows[k*col_length +: col_length]    = cur_row;
                ins_cols[k*col_length +: col_length]    = cur_col;
                ins_mask[k]                             = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = last_pix ? FLUSH : SCAN;
            SCAN:    if (accept && last_pix) state_nxt = FLUSH;
            FLUSH:   if (last_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Input stalls only while a beat is held, so a completed beat always has a free slot.
    always_comb begin
        ready   = !rst && (state != FLUSH) && (!out_valid || bus.out_ready);
        accept  = bus.in_valid && ready;
        emit    = accept && (last_pix || (keep && acc_fill == 2'd3));
        out_hs  = out_valid && bus.out_ready;
        last_hs = out_hs && out_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row         <= '0;
            col         <= '0;
            cnt         <= '0;
            acc_fill    <= '0;
            acc_value   <= '0;
            acc_rows    <= '0;
            acc_cols    <= '0;
            acc_mask    <= '0;
            out_value   <= '0;
            out_rows    <= '0;
            out_cols    <= '0;
            out_mask    <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_channel <= '0;
            valid_num   <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= last_hs;
            if (last_hs) valid_num <= cnt;
            if (out_hs) out_valid <= 1'b0;
            if (accept) begin
                if (state == IDLE) begin
                    out_channel <= bus.in_channel;
                    cnt         <= keep ? double_word_length'(1) : '0;
                end else if (keep) begin
                    cnt <= cnt + double_word_length'(1);
                end
                if (last_pix) begin
                    row <= '0;
                    col <= '0;
                end else if (cur_col == coord_max) begin
                    row <= cur_row + col_length'(1);
                    col <= '0;
                end else begin
                    row <= cur_row;
                    col <= cur_col + col_length'(1);
                end
                if (emit) begin
                    out_value <= ins_value;
                    out_rows  <= ins_rows;
                    out_cols  <= ins_cols;
                    out_mask  <= ins_mask;
                    out_last  <= last_pix;
                    out_valid <= 1'b1;
                    acc_value <= '0;
                    acc_rows  <= '0;
                    acc_cols  <= '0;
                    acc_mask  <= '0;
                    acc_fill  <= '0;
                end else begin
                    acc_value <= ins_value;
                    acc_rows  <= ins_rows;
                    acc_cols  <= ins_cols;
                    acc_mask  <= ins_mask;
                    acc_fill  <= acc_fill + {1'b0, keep};
                end
            end
        end
    end

    assign bus.in_ready          = ready;
    assign bus.out_valid         = out_valid;
    assign bus.feature_value     = out_value;
    assign bus.feature_rows      = out_rows;
    assign bus.feature_cols      = out_cols;
    assign bus.lane_mask         = out_mask;
    assign bus.out_last          = out_last;
    assign bus.out_channel       = out_channel;
    assign bus.feature_valid_num = valid_num;
    assign bus.frame_done        = frame_done;
endmodule

// File: tb/tb_sparse_feature_encoder.sv
// Scoreboard bench for sparse_feature_encoder: a pixel-level model queues expected beats and counts,
// a negedge monitor pops and compares them as the DUT hands them over.
module tb_sparse_feature_encoder;
    localparam int N = 28;

    typedef struct packed {
        logic [31:0] value;
        logic [31:0] rows;
        logic [31:0] cols;
        logic [3:0]  mask;
        logic        last;
        logic [15:0] ch;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sparse_feature_encoder_if bus ();
    sparse_feature_encoder dut (.clk(clk), .rst(rst), .bus(bus));

    beat_t       exp_q[$];
    logic [15:0] cnt_q[$];
    int vectors = 0, miscompares = 0, beats_seen = 0, done_seen = 0;
    logic [7:0]  img[N*N];

    beat_t       m_beat;
    int          m_fill;
    logic [15:0] m_cnt, m_ch;
    beat_t       prev_snap;
    bit          prev_stall;

    function automatic bit model_keep(input logic [7:0] p);
        int v;
        v = int'($signed(p));
`ifdef SPARSE_PRUNE_EN
        return ((v < 0) ? -v : v) > 2;
`else
        return v != 0;
`endif
    endfunction

    task automatic model_accept(input logic [7:0] px, input int r, input int c, input logic [15:0] ch);
        bit lastp;
        lastp = (r == N - 1) && (c == N - 1);
        if (r == 0 && c == 0) begin
            m_cnt = 0;
            m_ch  = ch;
        end
        if (model_keep(px)) begin
            m_beat.value[m_fill*8 +: 8] = px;
            m_beat.rows[m_fill*8 +: 8]  = r[7:0];
            m_beat.cols[m_fill*8 +: 8]  = c[7:0];
            m_beat.mask[m_fill]         = 1'b1;
            m_fill++;
            m_cnt++;
        end
        if (m_fill == 4 || lastp) begin
            m_beat.last = lastp;
            m_beat.ch   = m_ch;
            exp_q.push_back(m_beat);
            m_beat = '0;
            m_fill = 0;
        end
        if (lastp) cnt_q.push_back(m_cnt);
    endtask

    always @(negedge clk) begin
        beat_t cur, e;
        logic [15:0] ec;
        cur = {bus.feature_value, bus.feature_rows, bus.feature_cols, bus.lane_mask, bus.out_last, bus.out_channel};
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                vectors++;
                if (!bus.out_valid || cur !== prev_snap) begin
                    miscompares++;
                    $display("FAIL stall_hold: got valid=%b beat=%h, expected valid=1 beat=%h", bus.out_valid, cur, prev_snap);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                beats_seen++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL beat_unexpected: got mask=%b last=%b val=%h, expected no beat", cur.mask, cur.last, cur.value);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        miscompares++;
                        $display("FAIL beat: got mask=%b last=%b val=%h rows=%h cols=%h ch=%h, expected mask=%b last=%b val=%h rows=%h cols=%h ch=%h",
                                 cur.mask, cur.last, cur.value, cur.rows, cur.cols, cur.ch,
                                 e.mask, e.last, e.value, e.rows, e.cols, e.ch);
                    end
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_snap  = cur;
            if (bus.frame_done) begin
                done_seen++;
                vectors++;
                if (cnt_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL frame_done_unexpected: got count=%0d, expected no pulse", bus.feature_valid_num);
                end else begin
                    ec = cnt_q.pop_front();
                    if (bus.feature_valid_num !== ec) begin
                        miscompares++;
                        $display("FAIL valid_num: got %0d, expected %0d", bus.feature_valid_num, ec);
                    end
                end
            end
        end
    end

    task automatic send_pixel(input logic [7:0] px, input int r, input int c, input logic [15:0] ch);
        bit ok;
        ok = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_pixel   = px;
        bus.in_channel = ch;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (ok) begin
            model_accept(px, r, c, ch);
        end else begin
            vectors++;
            miscompares++;
            $display("FAIL in_ready_timeout: got in_ready=0 at (%0d,%0d), expected acceptance", r, c);
        end
    endtask

    task automatic drive_frame(input logic [15:0] ch);
        for (int i = 0; i < N * N; i++) send_pixel(img[i], i / N, i % N, ch);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 1000 && (exp_q.size() != 0 || cnt_q.size() != 0); k++) @(negedge clk);
        repeat (2) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0 || cnt_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d beats and %0d counts pending, expected 0", exp_q.size(), cnt_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_img();
        for (int i = 0; i < N * N; i++) img[i] = 8'h00;
    endtask

    task automatic check_int(input string name, input int got, input int want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors += 3;
        if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b, expected 0", bus.in_ready);
        end
        if ({bus.out_valid, bus.out_last, bus.frame_done, bus.lane_mask} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, expected 0", {bus.out_valid, bus.out_last, bus.frame_done, bus.lane_mask});
        end
        if ({bus.feature_value, bus.feature_rows, bus.feature_cols, bus.out_channel, bus.feature_valid_num} !== 128'b0) begin
            miscompares++;
            $display("FAIL reset_data: got %h, expected 0",
                     {bus.feature_value, bus.feature_rows, bus.feature_cols, bus.out_channel, bus.feature_valid_num});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_reset: got %b, expected 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_two_pixels();
        int d0;
        clear_img();
        img[3]          = 8'h1A;
        img[2 * N + 5]  = 8'hE6;
        d0 = done_seen;
        drive_frame(16'h1234);
        drain();
        check_int("two_px_count", int'(bus.feature_valid_num), 2);
        check_int("two_px_done_pulses", done_seen - d0, 1);
    endtask

    task automatic test_all_zero();
        int b0;
        clear_img();
        b0 = beats_seen;
        drive_frame(16'h0042);
        drain();
        check_int("zero_beats", beats_seen - b0, 1);
        check_int("zero_count", int'(bus.feature_valid_num), 0);
    endtask

    task automatic test_four_last();
        int b0;
        clear_img();
        img[100] = 8'h11;
        img[200] = 8'h22;
        img[300] = 8'h33;
        img[N * N - 1] = 8'h44;
        b0 = beats_seen;
        drive_frame(16'h0004);
        drain();
        check_int("four_last_beats", beats_seen - b0, 1);
    endtask

    task automatic test_dense_stall();
        int b0;
        for (int i = 0; i < N * N; i++) img[i] = 8'h01;
        b0 = beats_seen;
        fork
            drive_frame(16'h0003);
            begin
                repeat (100) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (k >= 6) begin
                        vectors++;
                        if (bus.in_ready !== 1'b0) begin
                            miscompares++;
                            $display("FAIL stall_in_ready: got %b at stall cycle %0d, expected 0", bus.in_ready, k);
                        end
                    end
                    @(posedge clk);
                end
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();
        check_int("dense_beats", beats_seen - b0, 196);
        check_int("dense_count", int'(bus.feature_valid_num), 784);
    endtask

    task automatic test_back_to_back();
        bit fdone;
        clear_img();
        for (int i = 0; i < N * N; i++) if ($urandom_range(0, 3) == 0) img[i] = 8'($urandom_range(1, 255));
        fdone = 1'b0;
        fork
            begin
                drive_frame(16'hBEEF);
                fdone = 1'b1;
            end
            begin
                while (!fdone) begin
                    @(posedge clk);
                    #1 bus.out_ready = 1'($urandom_range(0, 1));
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
    endtask

    task automatic test_reset_abort();
        int d0;
        clear_img();
        img[10]  = 8'h07;
        img[200] = 8'h09;
        d0 = done_seen;
        for (int i = 0; i < 300; i++) send_pixel(img[i], i / N, i % N, 16'h00AB);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        m_beat       = '0;
        m_fill       = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        clear_img();
        img[N + 1] = 8'h05;
        drive_frame(16'h0007);
        drain();
        check_int("abort_done_pulses", done_seen - d0, 1);
        check_int("abort_count", int'(bus.feature_valid_num), 1);
    endtask

    task automatic test_prune();
        int want;
`ifdef SPARSE_PRUNE_EN
        want = 2;
`else
        want = 4;
`endif
        clear_img();
        img[5]   = 8'h02;
        img[50]  = 8'hFE;
        img[400] = 8'h03;
        img[700] = 8'h80;
        drive_frame(16'h0099);
        drain();
        check_int("prune_count", int'(bus.feature_valid_num), want);
    endtask

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_pixel   = '0;
        bus.in_channel = '0;
        bus.out_ready  = 1'b1;
        m_beat         = '0;
        m_fill         = 0;
        m_cnt          = '0;
        m_ch           = '0;
        prev_stall     = 1'b0;
        prev_snap      = '0;
        test_reset();
        test_two_pixels();
        test_all_zero();
        test_four_last();
        test_dense_stall();
        test_back_to_back();
        test_reset_abort();
        test_prune();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
